differential_prbs_checker: RTL
==============================

Name: differential_prbs_checker

Overview:
- Receive-side bit-error-rate checker for the differential serial link test bench.
- Samples one differential bit per rising clock and self-seeds a PRBS reference LFSR from the incoming stream.
- Locks to the sequence, then counts received bits, bit errors and invalid symbols.
- Sits downstream of the error injector and delay line. The injector's error count is the expected value for this block's error count.

Parameters:
- LFSR_WIDTH, 7: PRBS register length. The polynomial is x^TAP_A + x^TAP_B + 1.
- TAP_A, 7: first feedback tap, 1-based. Must equal LFSR_WIDTH.
- TAP_B, 6: second feedback tap, 1-based. Must be less than TAP_A.
- LOCK_COUNT, 32: consecutive matching bits required in HUNT before declaring lock.
- WINDOW, 64: loss-of-lock observation window, in bits.
- UNLOCK_ERRORS, 8: number of errors within one window that forces relock.
- COUNT_WIDTH, 64: width of the bit and error counters.

Ports:
- clock, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- in_p, in, 1: positive leg of the differential data input.
- in_n, in, 1: negative leg of the differential data input.
- stop, in, 1: when high, counters freeze; tracking and lock logic continue.
- clear, in, 1: synchronous clear of all counters. Has no effect on state or LFSR.
- locked, out, 1: high while the FSM is in LOCKED.
- error, out, 1: one-cycle pulse per errored bit while LOCKED.
- bit_count, out, COUNT_WIDTH: number of bits checked while LOCKED.
- error_count, out, COUNT_WIDTH: number of errored bits while LOCKED.
- invalid_count, out, 16: number of invalid symbols seen in any state.
- lock_losses, out, 16: number of LOCKED to SEED transitions.

Behaviour:
- Symbol decode:
  - Valid when in_p ^ in_n = 1; the data bit is in_p.
  - Invalid when in_p == in_n. invalid_count increments in any state (subject to stop).
- Reference generator:
  - predicted = lfsr[TAP_A-1] ^ lfsr[TAP_B-1].
  - Shift rule: lfsr <= {lfsr[LFSR_WIDTH-2:0], shift_in}.
- Reset (reset low, asynchronous):
  - state = SEED; lfsr, seed_cnt, good_run, window counters = 0.
  - All outputs = 0.
- FSM, evaluated once per rising edge:
  - SEED:
    - A valid bit shifts in and increments seed_cnt.
    - An invalid symbol sets seed_cnt = 0.
    - When seed_cnt reaches LFSR_WIDTH: go to HUNT with good_run = 0.
  - HUNT:
    - A valid bit always shifts in (self-synchronising).
    - Bit equals predicted: good_run++. Otherwise, or on an invalid symbol: good_run = 0.
    - When good_run reaches LOCK_COUNT: go to LOCKED, with window counters = 0.
  - LOCKED:
    - The LFSR free-runs with shift_in = predicted; the received bit is not fed back.
    - A bit is errored if the symbol is invalid or the bit differs from predicted.
    - Per bit: bit_count++. For an errored bit: error_count++, error = 1 for that cycle, and win_err++.
    - win_bits++ on every bit. On reaching WINDOW, win_bits and win_err clear to 0.
    - If win_err reaches UNLOCK_ERRORS before the window closes: go to SEED, lock_losses++, locked = 0 on the same edge.
- Latency:
  - The symbol sampled at edge k is reflected in locked, error and all counters immediately after edge k.
  - A clean stream achieves lock LFSR_WIDTH + LOCK_COUNT edges after reset release (39 with defaults).
- Counters:
  - All counters saturate at all-ones; they never wrap.
  - stop = 1 holds bit_count, error_count and invalid_count, and the error pulse is suppressed.
  - stop does not hold lock_losses; the FSM and window still run.
- Simultaneous events:
  - clear has priority over increment; a bit arriving on a clear edge is not counted.
  - A loss-of-lock on the same edge as clear still transitions; lock_losses is cleared, so the loss is not counted.
- Reset during LOCKED: all state and counters return to 0 immediately. The next lock requires a full SEED and HUNT.

Test Plan:
- Clean PRBS7 (x^7+x^6+1) stream from reset: locked rises after edge 39. After 1000 further bits: bit_count = 1000, error_count = 0, error never pulses.
- Locked, then flip in_p and in_n on 3 isolated bits spaced 100 apart: error_count = 3, three single-cycle error pulses, locked stays 1.
- Locked, then 8 flipped bits within 20 bits: locked falls on the 8th error edge, lock_losses = 1, relock 39 bits later. Counters are preserved and resume counting.
- in_p = in_n = 1 for 1 cycle while locked: invalid_count = 1, error_count = 1. The same symbol during SEED restarts seeding, and lock is delayed by the seeded bits plus 1.
- stop = 1 for 50 locked bits with 2 injected errors: counters are unchanged and there are no error pulses. Assert clear: all counters read 0 on the next cycle.
- COUNT_WIDTH = 8 with a continuous error stream and UNLOCK_ERRORS above WINDOW: error_count stops at 255. Drop reset mid-lock: all outputs read 0 with no clock edge.

Source files
------------

// File: rtl/differential_prbs_checker.sv
// Receive-side PRBS bit-error-rate checker: decodes one differential symbol per clock,
// self-seeds a reference LFSR from the stream, locks, then counts bits, errors and invalid symbols.
module differential_prbs_checker #(
   parameter int LFSR_WIDTH    = 7,
   parameter int TAP_A         = 7,
   parameter int TAP_B         = 6,
   parameter int LOCK_COUNT    = 32,
   parameter int WINDOW        = 64,
   parameter int UNLOCK_ERRORS = 8,
   parameter int COUNT_WIDTH   = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_p,
   input  logic                   in_n,
   input  logic                   stop,
   input  logic                   clear,
   output logic                   locked,
   output logic                   error,
   output logic [COUNT_WIDTH-1:0] bit_count,
   output logic [COUNT_WIDTH-1:0] error_count,
   output logic [15:0]            invalid_count,
   output logic [15:0]            lock_losses,
   output logic [1:0]             state_dbg
);

   localparam int SW = $clog2(LFSR_WIDTH + 1);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(WINDOW + 1);
   localparam int EW = $clog2(UNLOCK_ERRORS + 1);

   typedef enum logic [1:0] {SEED = 2'd0, HUNT = 2'd1, LOCKED = 2'd2} state_t;

   state_t                state;
   logic [LFSR_WIDTH-1:0] lfsr;
   logic [SW-1:0]         seed_cnt;
   logic [GW-1:0]         good_run;
   logic [BW-1:0]         win_bits;
   logic [EW-1:0]         win_err;

   logic sym_valid;
   logic rx_bit;
   logic predicted;
   logic bit_err;
   logic unlock;

   assign sym_valid = in_p ^ in_n;
   assign rx_bit    = in_p;
   assign predicted = lfsr[TAP_A-1] ^ lfsr[TAP_B-1];
   assign bit_err   = !sym_valid || (rx_bit != predicted);
   assign unlock    = (state == LOCKED) && bit_err && (win_err == EW'(UNLOCK_ERRORS - 1));
   assign state_dbg = state;

   function automatic logic [COUNT_WIDTH-1:0] sat_w(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + COUNT_WIDTH'(1);
   endfunction

   function automatic logic [15:0] sat_16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= SEED;
         lfsr          <= '0;
         seed_cnt      <= '0;
         good_run      <= '0;
         win_bits      <= '0;
         win_err       <= '0;
         locked        <= 1'b0;
         error         <= 1'b0;
         bit_count     <= '0;
         error_count   <= '0;
         invalid_count <= '0;
         lock_losses   <= '0;
      end else begin
         error <= 1'b0;
         case (state)
            SEED: begin
               if (!sym_valid) begin
                  seed_cnt <= '0;
               end else begin
                  lfsr <= {lfsr[LFSR_WIDTH-2:0], rx_bit};
                  if (seed_cnt == SW'(LFSR_WIDTH - 1)) begin
                     seed_cnt <= '0;
                     good_run <= '0;
                     state    <= HUNT;
                  end else begin
                     seed_cnt <= seed_cnt + 1'b1;
                  end
               end
            end
            HUNT: begin
               // Received bits keep feeding the register so a bad seed washes out on its own.
               if (sym_valid) lfsr <= {lfsr[LFSR_WIDTH-2:0], rx_bit};
               if (sym_valid && (rx_bit == predicted)) begin
                  if (good_run == GW'(LOCK_COUNT - 1)) begin
                     good_run <= '0;
                     win_bits <= '0;
                     win_err  <= '0;
                     locked   <= 1'b1;
                     state    <= LOCKED;
                  end else begin
                     good_run <= good_run + 1'b1;
                  end
               end else begin
                  good_run <= '0;
               end
            end
            LOCKED: begin
               lfsr <= {lfsr[LFSR_WIDTH-2:0], predicted};
               if (bit_err && !stop) error <= 1'b1;
               if (unlock) begin
                  win_bits <= '0;
                  win_err  <= '0;
                  seed_cnt <= '0;
                  locked   <= 1'b0;
                  state    <= SEED;
               end else if (win_bits == BW'(WINDOW - 1)) begin
                  win_bits <= '0;
                  win_err  <= '0;
               end else begin
                  win_bits <= win_bits + 1'b1;
                  if (bit_err) win_err <= win_err + 1'b1;
               end
            end
            default: begin
               locked <= 1'b0;
               state  <= SEED;
            end
         endcase

         // Counters: clear wins over any increment on the same edge.
         if (clear) begin
            bit_count     <= '0;
            error_count   <= '0;
            invalid_count <= '0;
            lock_losses   <= '0;
         end else begin
            if (!stop && !sym_valid) invalid_count <= sat_16(invalid_count);
            if (state == LOCKED && !stop) begin
               bit_count <= sat_w(bit_count);
               if (bit_err) error_count <= sat_w(error_count);
            end
            if (unlock) lock_losses <= sat_16(lock_losses);
         end
      end
   end

endmodule
